// File: rtl/link_ctrl.sv
// link_ctrl: per-frame sequencer; one action strobe per frame tick, then map and character redraws.
// Define LINK_CTRL_TIMEOUT_EN to add the draw watchdog and the draw_timeout port.
module link_ctrl #(
`ifdef LINK_CTRL_TIMEOUT_EN
    parameter int unsigned TIMEOUT       = 65535,
`endif
    parameter int unsigned MAP_W         = 256,
    parameter int unsigned MAP_H         = 176,
    parameter int unsigned SPRITE        = 16,
    parameter int unsigned X_INIT        = 127,
    parameter int unsigned Y_INIT        = 88,
    parameter int unsigned ATTACK_FRAMES = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic frame_tick,
    input  logic btn_up,
    input  logic btn_down,
    input  logic btn_left,
    input  logic btn_right,
    input  logic btn_attack,
    input  logic map_draw_done,
    input  logic char_draw_done,
    output logic init,
    output logic idle,
    output logic attack,
    output logic move_up,
    output logic move_down,
    output logic move_left,
    output logic move_right,
    output logic draw_map,
    output logic draw_char,
    output logic frame_missed,
`ifdef LINK_CTRL_TIMEOUT_EN
    output logic draw_timeout,
`endif
    output logic busy
);
    localparam int unsigned POS_W = 8;
    localparam int unsigned CNT_W = 8;
    localparam logic [POS_W-1:0] X_MAX      = POS_W'(MAP_W - SPRITE);
    localparam logic [POS_W-1:0] Y_MAX      = POS_W'(MAP_H - SPRITE);
    localparam logic [CNT_W-1:0] ATK_RELOAD = CNT_W'(ATTACK_FRAMES - 1);
`ifdef LINK_CTRL_TIMEOUT_EN
    localparam int unsigned TO_W = 16;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
`endif

    typedef enum logic [2:0] {
        S_INIT,
        S_DRAW_MAP,
        S_DRAW_CHAR,
        S_WAIT,
        S_ACT
    } state_e;

    state_e             state_q;
    logic [POS_W-1:0]   pos_x_q, pos_x_d;
    logic [POS_W-1:0]   pos_y_q, pos_y_d;
    logic [CNT_W-1:0]   atk_cnt_q, atk_cnt_d;
    logic               pending_q;
    logic               init_q, idle_q, attack_q;
    logic               up_q, down_q, left_q, right_q;
    logic               draw_map_q, draw_char_q, frame_missed_q, busy_q;
    logic               idle_d, attack_d, up_d, down_d, left_d, right_d;
`ifdef LINK_CTRL_TIMEOUT_EN
    logic [TO_W-1:0]    to_cnt_q;
    logic               draw_timeout_q;
`endif

    // Action chosen for the next S_ACT from buttons, attack cooldown and shadow position
    always_comb begin
        idle_d    = 1'b0;
        attack_d  = 1'b0;
        up_d      = 1'b0;
        down_d    = 1'b0;
        left_d    = 1'b0;
        right_d   = 1'b0;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        atk_cnt_d = atk_cnt_q;
        if (atk_cnt_q != '0) begin
            idle_d    = 1'b1;
            atk_cnt_d = atk_cnt_q - CNT_W'(1);
        end else if (btn_attack) begin
            attack_d  = 1'b1;
            atk_cnt_d = ATK_RELOAD;
        end else if (btn_up) begin
            if (pos_y_q != '0) begin
                up_d    = 1'b1;
                pos_y_d = pos_y_q - POS_W'(1);
            end else begin
                idle_d  = 1'b1;
            end
        end else if (btn_down) begin
            if (pos_y_q < Y_MAX) begin
                down_d  = 1'b1;
                pos_y_d = pos_y_q + POS_W'(1);
            end else begin
                idle_d  = 1'b1;
            end
        end else if (btn_left) begin
            if (pos_x_q != '0) begin
                left_d  = 1'b1;
                pos_x_d = pos_x_q - POS_W'(1);
            end else begin
                idle_d  = 1'b1;
            end
        end else if (btn_right) begin
            if (pos_x_q < X_MAX) begin
                right_d = 1'b1;
                pos_x_d = pos_x_q + POS_W'(1);
            end else begin
                idle_d  = 1'b1;
            end
        end else begin
            idle_d = 1'b1;
        end
    end

    // Sequencer: outputs are registered alongside the state they describe
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= S_INIT;
            pos_x_q        <= POS_W'(X_INIT);
            pos_y_q        <= POS_W'(Y_INIT);
            atk_cnt_q      <= '0;
            pending_q      <= 1'b0;
            init_q         <= 1'b0;
            idle_q         <= 1'b0;
            attack_q       <= 1'b0;
            up_q           <= 1'b0;
            down_q         <= 1'b0;
            left_q         <= 1'b0;
            right_q        <= 1'b0;
            draw_map_q     <= 1'b0;
            draw_char_q    <= 1'b0;
            frame_missed_q <= 1'b0;
            busy_q         <= 1'b0;
`ifdef LINK_CTRL_TIMEOUT_EN
            to_cnt_q       <= '0;
            draw_timeout_q <= 1'b0;
`endif
        end else begin
            init_q         <= 1'b0;
            idle_q         <= 1'b0;
            attack_q       <= 1'b0;
            up_q           <= 1'b0;
            down_q         <= 1'b0;
            left_q         <= 1'b0;
            right_q        <= 1'b0;
            frame_missed_q <= 1'b0;
`ifdef LINK_CTRL_TIMEOUT_EN
            to_cnt_q       <= '0;
            draw_timeout_q <= 1'b0;
`endif
            // Ticks outside S_WAIT are remembered once; a second one is dropped
            if (frame_tick && state_q != S_WAIT) begin
                if (pending_q) begin
                    frame_missed_q <= 1'b1;
                end else begin
                    pending_q <= 1'b1;
                end
            end

            case (state_q)
                S_INIT: begin
                    busy_q <= 1'b1;
                    if (!init_q) begin
                        init_q <= 1'b1;
                    end else begin
                        state_q    <= S_DRAW_MAP;
                        draw_map_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (frame_tick || pending_q) begin
                        state_q   <= S_ACT;
                        pending_q <= 1'b0;
                        busy_q    <= 1'b1;
                        idle_q    <= idle_d;
                        attack_q  <= attack_d;
                        up_q      <= up_d;
                        down_q    <= down_d;
                        left_q    <= left_d;
                        right_q   <= right_d;
                        pos_x_q   <= pos_x_d;
                        pos_y_q   <= pos_y_d;
                        atk_cnt_q <= atk_cnt_d;
                    end
                end
                S_ACT: begin
                    state_q    <= S_DRAW_MAP;
                    draw_map_q <= 1'b1;
                end
                S_DRAW_MAP: begin
                    if (map_draw_done) begin
                        state_q     <= S_DRAW_CHAR;
                        draw_map_q  <= 1'b0;
                        draw_char_q <= 1'b1;
`ifdef LINK_CTRL_TIMEOUT_EN
                    end else if (to_cnt_q == TO_LAST) begin
                        state_q        <= S_WAIT;
                        draw_map_q     <= 1'b0;
                        busy_q         <= 1'b0;
                        draw_timeout_q <= 1'b1;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
`endif
                    end
                end
                S_DRAW_CHAR: begin
                    if (char_draw_done) begin
                        state_q     <= S_WAIT;
                        draw_char_q <= 1'b0;
                        busy_q      <= 1'b0;
`ifdef LINK_CTRL_TIMEOUT_EN
                    end else if (to_cnt_q == TO_LAST) begin
                        state_q        <= S_WAIT;
                        draw_char_q    <= 1'b0;
                        busy_q         <= 1'b0;
                        draw_timeout_q <= 1'b1;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
`endif
                    end
                end
                default: begin
                    state_q <= S_INIT;
                end
            endcase
        end
    end

    assign init         = init_q;
    assign idle         = idle_q;
    assign attack       = attack_q;
    assign move_up      = up_q;
    assign move_down    = down_q;
    assign move_left    = left_q;
    assign move_right   = right_q;
    assign draw_map     = draw_map_q;
    assign draw_char    = draw_char_q;
    assign frame_missed = frame_missed_q;
    assign busy         = busy_q;
`ifdef LINK_CTRL_TIMEOUT_EN
    assign draw_timeout = draw_timeout_q;
`endif

endmodule

// File: doc/link_ctrl.md
Name: link_ctrl

Overview:
- Per-frame sequencer for the player-character datapath and the map renderer.
- On each frame tick it samples the user buttons and issues exactly one action strobe: init, idle, attack or one move direction.
- It then runs the map redraw and the character draw back-to-back, waiting on each block's done handshake.
- It tracks a shadow copy of the character position so moves never push the 16x16 sprite off the 256x176 map.

Parameters:
- MAP_W, 256, map width in pixels
- MAP_H, 176, map height in pixels
- SPRITE, 16, sprite edge length in pixels
- X_INIT, 127, spawn x; must match the character block's init value
- Y_INIT, 88, spawn y; must match the character block's init value
- ATTACK_FRAMES, 8, frames an attack occupies; moves are ignored during these frames
- TIMEOUT, 65535, draw watchdog limit in cycles (used only with the optional feature)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per video frame
- btn_up, btn_down, btn_left, btn_right, btn_attack  in  1 each  debounced, level-sensitive buttons
- map_draw_done  in  1  one-cycle pulse from the map renderer
- char_draw_done  in  1  one-cycle pulse from the character block
- init, idle, attack, move_up, move_down, move_left, move_right  out  1 each  action strobes
- draw_map  out  1  held high while the map is redrawn
- draw_char  out  1  held high while the character is drawn
- frame_missed  out  1  one-cycle pulse when a frame tick is dropped
- busy  out  1  high in every state except S_WAIT

Behaviour:
- All outputs are registered. Every output is 0 during reset. The state register resets to S_INIT, shadow position to (X_INIT, Y_INIT), attack counter to 0, pending flag to 0.
- States: S_INIT -> S_DRAW_MAP -> S_DRAW_CHAR -> S_WAIT -> S_ACT -> S_DRAW_MAP ...
- S_INIT: lasts one cycle; init=1 exactly that cycle; the first frame is drawn without waiting for a tick.
- S_WAIT: idle=0, busy=0. On frame_tick, or if the pending flag is set, go to S_ACT and clear pending.
- S_ACT: one cycle; exactly one strobe is high. Selection:
  - If the attack counter is nonzero: idle=1, and the counter decrements.
  - Else if btn_attack: attack=1, counter loads ATTACK_FRAMES-1.
  - Else the first pressed button in priority order up > down > left > right.
  - A move is legal only if it stays in bounds: up requires y>0; down requires y<MAP_H-SPRITE (160); left requires x>0; right requires x<MAP_W-SPRITE (240). A legal move strobes move_* and steps the shadow position by 1.
  - A blocked move, or no button pressed, gives idle=1.
  - Opposing buttons (e.g. up and down together) resolve by priority only.
- S_DRAW_MAP: draw_map=1 from entry until the cycle map_draw_done is sampled high. The next cycle enters S_DRAW_CHAR with draw_map=0.
- S_DRAW_CHAR: draw_char=1 until char_draw_done is sampled. Then go to S_WAIT.
- A done pulse arriving in any other state is ignored.
- A frame_tick arriving while busy=1 sets pending if pending=0. If pending is already 1, the tick is dropped and frame_missed pulses for one cycle.
- A frame_tick and a return to S_WAIT in the same cycle: the tick sets pending, and S_WAIT exits on the following cycle.
- Reset asserted mid-draw aborts immediately. All strobes drop in the next cycle and sequencing restarts from S_INIT.
- Position arithmetic is 8-bit unsigned. The bounds checks guarantee no wrap.

Optional Feature:
- Macro: LINK_CTRL_TIMEOUT_EN.
- Defined:
  - A 16-bit cycle counter runs in S_DRAW_MAP and S_DRAW_CHAR and clears on every state change.
  - On reaching TIMEOUT, the current draw strobe drops and the block goes to S_WAIT.
  - Output draw_timeout (1 bit) pulses for one cycle; this port exists only when the macro is defined.
- Undefined: no counter and no draw_timeout port; the block waits indefinitely for done.

Test Plan:
- Reset release, hold both done inputs low for 10 cycles -> init=1 for one cycle, then draw_map=1 continuously; pulse map_draw_done -> draw_char=1 next cycle; pulse char_draw_done -> busy=0.
- From spawn, hold btn_right, 120 ticks with prompt dones -> 113 move_right strobes (x 127->240), then idle strobes; shadow x=240.
- Hold btn_up and btn_down together, one tick -> move_up=1 only; y 88->87.
- Press btn_attack for one tick, then hold btn_left -> attack=1 once, then 7 idle strobes, then move_left on the 9th tick.
- Issue 3 frame_ticks during a single S_DRAW_MAP -> first tick sets pending, frame_missed pulses twice, and S_ACT is entered one cycle after the block returns to S_WAIT.
- With LINK_CTRL_TIMEOUT_EN and TIMEOUT=100, never assert map_draw_done -> draw_map falls after 100 cycles, draw_timeout pulses once, busy=0.
